sha_wb_feeder: RTL and testbench

//  Wishbone initiator that drives the SHA-256 peripheral (CMD @0x0, DIN @0x4, HASH @0x8).

---
 rtl/sha_wb_pkg.sv | 30 +++
 rtl/sha_wb_single_xfer.sv | 73 +++++++
 rtl/sha_wb_feeder.sv | 215 +++++++++++++++++++++
 tb/tb_sha_wb_feeder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_wb_pkg.sv
// Shared constants and FSM state type for the SHA-256 Wishbone feeder.
package sha_wb_pkg;

   // Register map of the SHA-256 slave
   localparam logic [3:0] ADR_CMD  = 4'h0;
   localparam logic [3:0] ADR_DIN  = 4'h4;
   localparam logic [3:0] ADR_HASH = 4'h8;

   // CMD register bit positions
   localparam int CMD_INIT = 0;
   localparam int CMD_DONE = 1;

   // Value written to CMD to start a new hash (clears done, rewinds hash index)
   localparam logic [31:0] CMD_INIT_WORD = 32'(1) << CMD_INIT;

   // Number of 32-bit words in the digest
   localparam int HASH_WORDS = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_INIT,
      S_FEED,
      S_POLL,
      S_RDHASH,
      S_DONE,
      S_ERR
   } state_t;

endpackage

// File: rtl/sha_wb_single_xfer.sv
// Registered Wishbone classic single-transfer master. A req pulse while idle
// launches one transfer; bus signals are held until ACK or ERR, then STB drops
// and a one-cycle done or err pulse is returned together with the read data.
module sha_wb_single_xfer (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [3:0]  adr_i,
   input  logic [31:0] wdat_i,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] rdat_o,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic [3:0]  adr_o,
   output logic [31:0] dat_o,
   input  logic        ack_i,
   input  logic        err_i,
   input  logic [31:0] dat_i
);

   logic        stb_q;
   logic        we_q;
   logic [3:0]  adr_q;
   logic [31:0] dat_q;
   logic        done_q;
   logic        err_q;
   logic [31:0] rdat_q;

   // Launch a transfer on req, hold it until the slave terminates it
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stb_q  <= 1'b0;
         we_q   <= 1'b0;
         adr_q  <= '0;
         dat_q  <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (stb_q) begin
            if (ack_i || err_i) begin
               stb_q  <= 1'b0;
               done_q <= ack_i && !err_i;
               err_q  <= err_i;
            end
         end else if (req_i) begin
            stb_q <= 1'b1;
            we_q  <= we_i;
            adr_q <= adr_i;
            dat_q <= wdat_i;
         end
      end
   end

   // Capture read data on the acknowledging cycle
   always_ff @(posedge clk_i) begin
      if (stb_q && ack_i) rdat_q <= dat_i;
   end

   assign done_o = done_q;
   assign err_o  = err_q;
   assign rdat_o = rdat_q;
   assign cyc_o  = stb_q;
   assign stb_o  = stb_q;
   assign we_o   = we_q;
   assign adr_o  = adr_q;
   assign dat_o  = dat_q;

endmodule

// File: rtl/sha_wb_feeder.sv
// Wishbone initiator driving a SHA-256 slave: init, stream a pre-padded
// message to DIN, poll CMD.done, read back the 8-word digest.
module sha_wb_feeder
   import sha_wb_pkg::*;
#(
   parameter int POLL_MAX = 1024,
   parameter int CNT_W    = 16
) (
   input  logic             CLK_I,
   input  logic             RST_I,
   input  logic             start,
   input  logic [CNT_W-1:0] nwords,
   input  logic             din_valid,
   input  logic [31:0]      din,
   output logic             din_ready,
   output logic             busy,
   output logic             hash_valid,
   output logic [255:0]     hash,
   output logic             err,
   output logic             M_CYC_O,
   output logic             M_STB_O,
   output logic             M_WE_O,
   output logic [3:0]       M_ADR_O,
   output logic [31:0]      M_DAT_O,
   output logic [3:0]       M_SEL_O,
   output logic [2:0]       M_CTI_O,
   output logic [1:0]       M_BTE_O,
   output logic             M_LOCK_O,
   input  logic             M_ACK_I,
   input  logic             M_ERR_I,
   input  logic [31:0]      M_DAT_I
);

   // Poll counter must be able to hold POLL_MAX+1
   localparam int             PW       = $clog2(POLL_MAX + 2);
   localparam logic [PW-1:0]  POLL_LIM = PW'(POLL_MAX);
   localparam logic [2:0]     LAST_IDX = 3'(HASH_WORDS - 1);

   state_t           state_q;
   logic [CNT_W-1:0] rem_q;
   logic [CNT_W-1:0] rem_d;
   logic [PW-1:0]    poll_q;
   logic [PW-1:0]    poll_d;
   logic [2:0]       idx_q;
   logic [255:0]     hash_q;
   logic             req_q;
   logic             we_q;
   logic [3:0]       adr_q;
   logic [31:0]      wdat_q;
   logic             wait_q;
   logic             busy_q;
   logic             hv_q;
   logic             err_q;

   logic             x_done;
   logic             x_err;
   logic [31:0]      x_rdat;
   logic             take;

   // Saturating next values for the word and poll counters
   assign rem_d  = (rem_q == '0) ? rem_q : rem_q - CNT_W'(1);
   assign poll_d = (poll_q > POLL_LIM) ? poll_q : poll_q + PW'(1);

   // Accept a stream word only while no bus transfer is outstanding
   assign din_ready = (state_q == S_FEED) && !wait_q && (rem_q != '0);
   assign take      = din_ready && din_valid;

   // Control FSM; issues bus requests as one-cycle req pulses
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         poll_q  <= '0;
         idx_q   <= '0;
         hash_q  <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         wdat_q  <= '0;
         wait_q  <= 1'b0;
         busy_q  <= 1'b0;
         hv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         req_q <= 1'b0;
         hv_q  <= 1'b0;
         err_q <= 1'b0;
         if (x_done) wait_q <= 1'b0;
         if (x_err) begin
            wait_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_ERR;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     rem_q   <= nwords;
                     busy_q  <= 1'b1;
                     state_q <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  if (rem_q == '0 || rem_q[3:0] != 4'h0) begin
                     err_q   <= 1'b1;
                     state_q <= S_ERR;
                  end else begin
                     req_q   <= 1'b1;
                     we_q    <= 1'b1;
                     adr_q   <= ADR_CMD;
                     wdat_q  <= CMD_INIT_WORD;
                     wait_q  <= 1'b1;
                     state_q <= S_INIT;
                  end
               end
               S_INIT: begin
                  if (x_done) state_q <= S_FEED;
               end
               S_FEED: begin
                  if (take) begin
                     req_q  <= 1'b1;
                     we_q   <= 1'b1;
                     adr_q  <= ADR_DIN;
                     wdat_q <= din;
                     wait_q <= 1'b1;
                     rem_q  <= rem_d;
                  end else if (x_done && rem_q == '0) begin
                     req_q   <= 1'b1;
                     we_q    <= 1'b0;
                     adr_q   <= ADR_CMD;
                     wait_q  <= 1'b1;
                     poll_q  <= '0;
                     state_q <= S_POLL;
                  end
               end
               S_POLL: begin
                  if (x_done) begin
                     if (x_rdat[CMD_DONE]) begin
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        adr_q   <= ADR_HASH;
                        wait_q  <= 1'b1;
                        idx_q   <= '0;
                        state_q <= S_RDHASH;
                     end else if (poll_d > POLL_LIM) begin
                        poll_q  <= poll_d;
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                     end else begin
                        poll_q <= poll_d;
                        req_q  <= 1'b1;
                        we_q   <= 1'b0;
                        adr_q  <= ADR_CMD;
                        wait_q <= 1'b1;
                     end
                  end
               end
               S_RDHASH: begin
                  if (x_done) begin
                     hash_q[{LAST_IDX - idx_q, 5'd0} +: 32] <= x_rdat;
                     if (idx_q == LAST_IDX) begin
                        hv_q    <= 1'b1;
                        state_q <= S_DONE;
                     end else begin
                        idx_q  <= idx_q + 3'd1;
                        req_q  <= 1'b1;
                        we_q   <= 1'b0;
                        adr_q  <= ADR_HASH;
                        wait_q <= 1'b1;
                     end
                  end
               end
               S_DONE: begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               S_ERR: begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   sha_wb_single_xfer u_xfer (
      .clk_i  (CLK_I),
      .rst_i  (RST_I),
      .req_i  (req_q),
      .we_i   (we_q),
      .adr_i  (adr_q),
      .wdat_i (wdat_q),
      .done_o (x_done),
      .err_o  (x_err),
      .rdat_o (x_rdat),
      .cyc_o  (M_CYC_O),
      .stb_o  (M_STB_O),
      .we_o   (M_WE_O),
      .adr_o  (M_ADR_O),
      .dat_o  (M_DAT_O),
      .ack_i  (M_ACK_I),
      .err_i  (M_ERR_I),
      .dat_i  (M_DAT_I)
   );

   assign busy       = busy_q;
   assign hash_valid = hv_q;
   assign hash       = hash_q;
   assign err        = err_q;
   assign M_SEL_O    = 4'hF;
   assign M_CTI_O    = 3'b000;
   assign M_BTE_O    = 2'b00;
   assign M_LOCK_O   = 1'b0;

endmodule

// File: tb/tb_sha_wb_feeder.sv
// Directed bench for sha_wb_feeder with a behavioural SHA slave that returns
// a programmable digest and logs every DIN word it receives.
module tb_sha_wb_feeder;

   localparam int POLL_MAX = 4;
   localparam int CNT_W    = 16;
   localparam logic [255:0] ABC_DIGEST =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] IV_DIGEST =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   logic             CLK_I = 1'b0;
   logic             RST_I = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] nwords = '0;
   logic             din_valid = 1'b0;
   logic [31:0]      din = '0;
   logic             din_ready, busy, hash_valid, err;
   logic [255:0]     hash;
   logic             M_CYC_O, M_STB_O, M_WE_O, M_LOCK_O;
   logic [3:0]       M_ADR_O, M_SEL_O;
   logic [31:0]      M_DAT_O;
   logic [2:0]       M_CTI_O;
   logic [1:0]       M_BTE_O;
   logic             M_ACK_I, M_ERR_I;
   logic [31:0]      M_DAT_I;

   always #5 CLK_I = ~CLK_I;

   sha_wb_feeder #(.POLL_MAX(POLL_MAX), .CNT_W(CNT_W)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I), .start(start), .nwords(nwords),
      .din_valid(din_valid), .din(din), .din_ready(din_ready), .busy(busy),
      .hash_valid(hash_valid), .hash(hash), .err(err),
      .M_CYC_O(M_CYC_O), .M_STB_O(M_STB_O), .M_WE_O(M_WE_O), .M_ADR_O(M_ADR_O),
      .M_DAT_O(M_DAT_O), .M_SEL_O(M_SEL_O), .M_CTI_O(M_CTI_O), .M_BTE_O(M_BTE_O),
      .M_LOCK_O(M_LOCK_O), .M_ACK_I(M_ACK_I), .M_ERR_I(M_ERR_I), .M_DAT_I(M_DAT_I)
   );

   // ---------------- slave model ----------------
   int          s_done_at = 2;     // CMD read number (1-based) that returns done; 0 = never
   int          s_err_on_din = 0;  // DIN write number that gets M_ERR_I; 0 = none
   logic [31:0] s_digest [0:7];
   logic        s_ack = 1'b0, s_err = 1'b0;
   int          s_pollcnt = 0, s_dincnt = 0, s_hidx = 0;
   int          n_cmdwr = 0, n_dinwr = 0, n_cmdrd = 0, n_hashrd = 0, n_bad = 0;
   logic [31:0] last_init = '0;
   logic [31:0] din_log [0:63];
   logic        new_req, inj;

   assign new_req = M_STB_O && M_CYC_O && !s_ack && !s_err;
   assign inj     = M_WE_O && (M_ADR_O == 4'h4) && (s_err_on_din != 0) && (s_dincnt + 1 == s_err_on_din);
   assign M_ACK_I = s_ack;
   assign M_ERR_I = s_err;

   always_comb begin
      M_DAT_I = 32'hDEAD_BEEF;
      if (!M_WE_O && M_ADR_O == 4'h0)
         M_DAT_I = (s_done_at != 0 && s_pollcnt + 1 >= s_done_at) ? 32'h2 : 32'h0;
      else if (!M_WE_O && M_ADR_O == 4'h8)
         M_DAT_I = s_digest[s_hidx[2:0]];
   end

   always @(posedge CLK_I) begin
      if (RST_I) begin
         s_ack <= 1'b0;
         s_err <= 1'b0;
      end else begin
         s_ack <= new_req && !inj;
         s_err <= new_req && inj;
      end
      if (M_STB_O && s_ack) begin
         if (M_WE_O && M_ADR_O == 4'h0) begin
            n_cmdwr <= n_cmdwr + 1; last_init <= M_DAT_O;
            s_dincnt <= 0; s_pollcnt <= 0; s_hidx <= 0;
         end else if (M_WE_O && M_ADR_O == 4'h4) begin
            din_log[s_dincnt[5:0]] <= M_DAT_O;
            s_dincnt <= s_dincnt + 1; n_dinwr <= n_dinwr + 1;
         end else if (!M_WE_O && M_ADR_O == 4'h0) begin
            s_pollcnt <= s_pollcnt + 1; n_cmdrd <= n_cmdrd + 1;
         end else if (!M_WE_O && M_ADR_O == 4'h8) begin
            s_hidx <= s_hidx + 1; n_hashrd <= n_hashrd + 1;
         end else begin
            n_bad <= n_bad + 1;
         end
      end
   end

   // ---------------- monitors ----------------
   int hv_cyc = 0, err_cyc = 0, stb_cyc = 0, stb_run = 0, stb_max = 0, cycstb_bad = 0;
   always @(posedge CLK_I) begin
      hv_cyc  <= hv_cyc + (hash_valid ? 1 : 0);
      err_cyc <= err_cyc + (err ? 1 : 0);
      stb_cyc <= stb_cyc + (M_STB_O ? 1 : 0);
      stb_run <= M_STB_O ? stb_run + 1 : 0;
      if (M_STB_O && stb_run + 1 > stb_max) stb_max <= stb_run + 1;
      if (M_CYC_O != M_STB_O) cycstb_bad <= cycstb_bad + 1;
   end

   // ---------------- checking helpers ----------------
   int checks = 0, errors = 0;
   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [31:0] msg [0:63];
   int hv0, er0, stb0, cw0, dw0, cr0, hr0;

   task automatic snap();
      hv0 = hv_cyc; er0 = err_cyc; stb0 = stb_cyc;
      cw0 = n_cmdwr; dw0 = n_dinwr; cr0 = n_cmdrd; hr0 = n_hashrd;
   endtask

   task automatic load_abc();
      for (int i = 0; i < 64; i++) msg[i] = 32'h0;
      msg[0]  = 32'h61626380;
      msg[15] = 32'h00000018;
      s_digest[0] = 32'hba7816bf; s_digest[1] = 32'h8f01cfea;
      s_digest[2] = 32'h414140de; s_digest[3] = 32'h5dae2223;
      s_digest[4] = 32'hb00361a3; s_digest[5] = 32'h96177a9c;
      s_digest[6] = 32'hb410ff61; s_digest[7] = 32'hf20015ad;
   endtask

   task automatic start_msg(input int n);
      @(negedge CLK_I);
      nwords = CNT_W'(n);
      start  = 1'b1;
      @(negedge CLK_I);
      start  = 1'b0;
   endtask

   task automatic feed(input int n, input bit gap, output int got);
      int cyc = 0;
      got = 0;
      while (got < n && cyc < 3000 && busy) begin
         @(negedge CLK_I);
         cyc++;
         din       = msg[got];
         din_valid = gap ? (cyc % 3 != 0) : 1'b1;
         if (din_valid && din_ready) got++;
      end
      @(negedge CLK_I);
      din_valid = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      int k = 0;
      while (!hash_valid && !err && k < 2000) begin
         @(negedge CLK_I);
         k++;
      end
      check({tag, "_no_timeout"}, 256'(k < 2000), 256'(1));
   endtask

   task automatic din_words(input string tag, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) if (din_log[i] !== msg[i]) bad++;
      check(tag, 256'(bad), 256'(0));
   endtask

   task automatic run_abc(input string tag);
      int got;
      load_abc();
      snap();
      start_msg(16);
      feed(16, 1'b0, got);
      wait_end(tag);
      check({tag, "_hv_seen"}, 256'(hash_valid), 256'(1));
      repeat (3) @(negedge CLK_I);
      check({tag, "_hash"}, hash, ABC_DIGEST);
      check({tag, "_hv_pulses"}, 256'(hv_cyc - hv0), 256'(1));
      check({tag, "_no_err"}, 256'(err_cyc - er0), 256'(0));
      check({tag, "_din_writes"}, 256'(n_dinwr - dw0), 256'(16));
      check({tag, "_hash_reads"}, 256'(n_hashrd - hr0), 256'(8));
      check({tag, "_busy_low"}, 256'(busy), 256'(0));
      din_words({tag, "_din_words"}, 16);
   endtask

   task automatic bad_len(input string tag, input int n);
      snap();
      start_msg(n);
      check({tag, "_busy"}, 256'({busy, err}), 256'(2'b10));
      @(negedge CLK_I);
      check({tag, "_err_pulse"}, 256'(err), 256'(1));
      @(negedge CLK_I);
      check({tag, "_after"}, 256'({busy, err}), 256'(2'b00));
      check({tag, "_no_stb"}, 256'(stb_cyc - stb0), 256'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int got;
      load_abc();
      repeat (3) @(negedge CLK_I);
      RST_I = 1'b0;
      @(negedge CLK_I);
      check("rst_ctrl", 256'({busy, hash_valid, err, din_ready, M_CYC_O, M_STB_O, M_WE_O}), 256'(0));
      check("rst_bus", 256'({M_ADR_O, M_DAT_O}), 256'(0));
      check("rst_hash", hash, 256'(0));
      check("const_outs", 256'({M_SEL_O, M_CTI_O, M_BTE_O, M_LOCK_O}), 256'(10'b1111_000000));

      // "abc" block, done reported on second poll
      s_done_at = 2;
      run_abc("abc");
      check("abc_init_write", 256'(n_cmdwr - cw0), 256'(1));
      check("abc_init_data", 256'(last_init), 256'(32'h1));
      check("abc_polls", 256'(n_cmdrd - cr0), 256'(2));
      check("abc_total_xfers", 256'((n_cmdwr - cw0) + (n_dinwr - dw0) + (n_cmdrd - cr0) + (n_hashrd - hr0)), 256'(27));

      // illegal lengths
      bad_len("len0", 0);
      bad_len("len17", 17);

      // slave never reports done: POLL_MAX+1 reads then timeout
      s_done_at = 0;
      snap();
      start_msg(16);
      feed(16, 1'b0, got);
      wait_end("timeout");
      check("timeout_err", 256'({err, hash_valid}), 256'(2'b10));
      check("timeout_cyc_at_err", 256'(M_CYC_O), 256'(0));
      @(negedge CLK_I);
      check("timeout_after", 256'({M_CYC_O, err}), 256'(0));
      check("timeout_polls", 256'(n_cmdrd - cr0), 256'(5));
      check("timeout_no_hash_reads", 256'(n_hashrd - hr0), 256'(0));
      @(negedge CLK_I);
      check("timeout_busy_low", 256'(busy), 256'(0));

      // done arrives on the last permitted poll
      s_done_at = 5;
      run_abc("poll5");
      check("poll5_polls", 256'(n_cmdrd - cr0), 256'(5));

      // 32-word message with din_valid low every third cycle
      s_done_at = 1;
      for (int i = 0; i < 32; i++) msg[i] = {16'hC0DE, 16'(i * 7 + 1)};
      s_digest[0] = 32'h6a09e667; s_digest[1] = 32'hbb67ae85;
      s_digest[2] = 32'h3c6ef372; s_digest[3] = 32'ha54ff53a;
      s_digest[4] = 32'h510e527f; s_digest[5] = 32'h9b05688c;
      s_digest[6] = 32'h1f83d9ab; s_digest[7] = 32'h5be0cd19;
      snap();
      start_msg(32);
      feed(32, 1'b1, got);
      wait_end("gap32");
      repeat (3) @(negedge CLK_I);
      check("gap32_hash", hash, IV_DIGEST);
      check("gap32_hv_pulses", 256'(hv_cyc - hv0), 256'(1));
      check("gap32_din_writes", 256'(n_dinwr - dw0), 256'(32));
      din_words("gap32_din_words", 32);
      check("gap32_stb_run", 256'(stb_max <= 2), 256'(1));

      // bus error on the fifth DIN write, then a clean run
      s_done_at = 2;
      s_err_on_din = 5;
      load_abc();
      snap();
      start_msg(16);
      feed(16, 1'b0, got);
      repeat (2) @(negedge CLK_I);
      check("buserr_words_taken", 256'(got), 256'(5));
      check("buserr_err_pulses", 256'(err_cyc - er0), 256'(1));
      check("buserr_no_hv", 256'(hv_cyc - hv0), 256'(0));
      check("buserr_din_acked", 256'(n_dinwr - dw0), 256'(4));
      check("buserr_idle", 256'({busy, M_CYC_O}), 256'(0));
      s_err_on_din = 0;
      run_abc("after_buserr");

      // reset in the middle of FEED
      load_abc();
      snap();
      start_msg(16);
      feed(6, 1'b0, got);
      @(negedge CLK_I);
      check("rstmid_stb_before", 256'(M_STB_O), 256'(1));
      RST_I = 1'b1;
      @(negedge CLK_I);
      check("rstmid_ctrl", 256'({busy, hash_valid, err, din_ready, M_CYC_O, M_STB_O, M_WE_O}), 256'(0));
      check("rstmid_bus", 256'({M_ADR_O, M_DAT_O}), 256'(0));
      check("rstmid_hash", hash, 256'(0));
      RST_I = 1'b0;
      repeat (2) @(negedge CLK_I);
      check("rstmid_no_err", 256'(err_cyc - er0), 256'(0));
      run_abc("after_rst");

      check("stb_max_run", 256'(stb_max <= 2), 256'(1));
      check("cyc_eq_stb", 256'(cycstb_bad), 256'(0));
      check("no_bad_access", 256'(n_bad), 256'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
